// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out handshake bundle for imm_gen_pipe.
// slave = the generator, master = the fetch-side producer plus decode-side consumer.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_inst;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_imm;
    logic [2:0]         out_fmt;
    logic               out_illegal;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, in_inst, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_inst, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with format tag and illegal flag.
// Latency 1 cycle; 2-entry main+skid buffer, in_ready is registered (!skid valid).
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    imm_gen_pipe_if.slave bus
);
    localparam logic [2:0] FMT_R     = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;
    localparam logic [2:0] FMT_ILL   = 3'd7;

    logic [XLEN-1:0]  w_imm;
    logic [2:0]       w_fmt;
    logic             w_ill;
    logic             w_accept;
    logic             w_drain;

    logic             r_main_vld;
    logic [XLEN-1:0]  r_main_imm;
    logic [2:0]       r_main_fmt;
    logic             r_main_ill;
    logic [TAG_W-1:0] r_main_tag;

    logic             r_skid_vld;
    logic [XLEN-1:0]  r_skid_imm;
    logic [2:0]       r_skid_fmt;
    logic             r_skid_ill;
    logic [TAG_W-1:0] r_skid_tag;

    always_comb begin
        w_imm = '0;
        w_fmt = FMT_ILL;
        w_ill = 1'b1;
        case (bus.in_inst[6:0])
            7'b0000011, 7'b0001111, 7'b1100111, 7'b1110011: begin
                w_fmt = FMT_I;
                w_ill = 1'b0;
                w_imm = XLEN'($signed(bus.in_inst[31:20]));
            end
            7'b0010011: begin
                w_ill = 1'b0;
                // funct3 001/101 are shifts: keep only the shamt, drop funct7
                if (bus.in_inst[13:12] == 2'b01) begin
                    w_fmt = FMT_SHAMT;
                    if (XLEN == 64) w_imm = XLEN'(bus.in_inst[25:20]);
                    else            w_imm = XLEN'(bus.in_inst[24:20]);
                end else begin
                    w_fmt = FMT_I;
                    w_imm = XLEN'($signed(bus.in_inst[31:20]));
                end
            end
            7'b0100011: begin
                w_fmt = FMT_S;
                w_ill = 1'b0;
                w_imm = XLEN'($signed({bus.in_inst[31:25], bus.in_inst[11:7]}));
            end
            7'b1100011: begin
                w_fmt = FMT_B;
                w_ill = 1'b0;
                w_imm = XLEN'($signed({bus.in_inst[31], bus.in_inst[7],
                                       bus.in_inst[30:25], bus.in_inst[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                w_fmt = FMT_U;
                w_ill = 1'b0;
                w_imm = XLEN'($signed({bus.in_inst[31:12], 12'b0}));
            end
            7'b1101111: begin
                w_fmt = FMT_J;
                w_ill = 1'b0;
                w_imm = XLEN'($signed({bus.in_inst[31], bus.in_inst[19:12],
                                       bus.in_inst[20], bus.in_inst[30:21], 1'b0}));
            end
            7'b0110011, 7'b0111011: begin
                w_fmt = FMT_R;
                w_ill = 1'b0;
            end
            default: begin
                w_fmt = FMT_ILL;
                w_ill = 1'b1;
            end
        endcase
    end

    assign w_accept = bus.in_valid && !r_skid_vld;
    assign w_drain  = r_main_vld && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_vld <= 1'b0;
            r_main_imm <= '0;
            r_main_fmt <= '0;
            r_main_ill <= 1'b0;
            r_main_tag <= '0;
            r_skid_vld <= 1'b0;
            r_skid_imm <= '0;
            r_skid_fmt <= '0;
            r_skid_ill <= 1'b0;
            r_skid_tag <= '0;
        end else begin
            // skid full means in_ready was low, so no accept competes with the refill
            if (w_drain && r_skid_vld) begin
                r_main_imm <= r_skid_imm;
                r_main_fmt <= r_skid_fmt;
                r_main_ill <= r_skid_ill;
                r_main_tag <= r_skid_tag;
                r_skid_vld <= 1'b0;
            end else if (w_accept && (!r_main_vld || w_drain)) begin
                r_main_vld <= 1'b1;
                r_main_imm <= w_imm;
                r_main_fmt <= w_fmt;
                r_main_ill <= w_ill;
                r_main_tag <= bus.in_tag;
            end else if (w_accept) begin
                r_skid_vld <= 1'b1;
                r_skid_imm <= w_imm;
                r_skid_fmt <= w_fmt;
                r_skid_ill <= w_ill;
                r_skid_tag <= bus.in_tag;
            end else if (w_drain) begin
                r_main_vld <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = !r_skid_vld;
    assign bus.out_valid   = r_main_vld;
    assign bus.out_imm     = r_main_imm;
    assign bus.out_fmt     = r_main_fmt;
    assign bus.out_illegal = r_main_ill;
    assign bus.out_tag     = r_main_tag;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed decode tables (XLEN 32 and 64),
// backpressure, randomized handshake against a reference model, and mid-run reset.
module tb_imm_gen_pipe;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) if32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) if64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode straight from the ISA field layout, using signed 64-bit arithmetic.
    function automatic void ref_decode(input logic [31:0] inst, input bit is64,
                                       output logic [63:0] imm, output logic [2:0] fmt);
        longint si;
        longint u;
        longint r;
        si  = longint'($signed(inst));
        u   = longint'(inst);
        r   = 0;
        fmt = 3'd7;
        case (inst[6:0])
            7'h03, 7'h0F, 7'h67, 7'h73: begin fmt = 3'd1; r = si >>> 20; end
            7'h13: begin
                if (inst[13:12] == 2'b01) begin
                    fmt = 3'd6;
                    r = is64 ? ((u >> 20) & 63) : ((u >> 20) & 31);
                end else begin
                    fmt = 3'd1;
                    r = si >>> 20;
                end
            end
            7'h23: begin fmt = 3'd2; r = ((si >>> 25) << 5) | ((u >> 7) & 31); end
            7'h63: begin
                fmt = 3'd3;
                r = ((si >>> 31) << 12) | (((u >> 7) & 1) << 11) |
                    (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
            end
            7'h37, 7'h17: begin fmt = 3'd4; r = (si >>> 12) << 12; end
            7'h6F: begin
                fmt = 3'd5;
                r = ((si >>> 31) << 20) | (((u >> 12) & 255) << 12) |
                    (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
            end
            7'h33, 7'h3B: begin fmt = 3'd0; r = 0; end
            default: begin fmt = 3'd7; r = 0; end
        endcase
        imm = r;
        if (!is64) imm[63:32] = 32'h0;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        if32.in_valid = 1'b0; if32.in_inst = '0; if32.in_tag = '0; if32.out_ready = 1'b0;
        if64.in_valid = 1'b0; if64.in_inst = '0; if64.in_tag = '0; if64.out_ready = 1'b1;
        #12;
        n_checks++;
        if (if32.out_valid !== 1'b0 || if32.in_ready !== 1'b1 || if32.out_imm !== 32'h0 ||
            if32.out_fmt !== 3'd0 || if32.out_illegal !== 1'b0 || if32.out_tag !== 32'h0) begin
            n_fail++;
            $display("FAIL reset32: vld=%b rdy=%b imm=%h fmt=%0d ill=%b tag=%h, expected 0 1 0 0 0 0",
                     if32.out_valid, if32.in_ready, if32.out_imm, if32.out_fmt,
                     if32.out_illegal, if32.out_tag);
        end
        n_checks++;
        if (if64.out_valid !== 1'b0 || if64.in_ready !== 1'b1 || if64.out_imm !== 64'h0) begin
            n_fail++;
            $display("FAIL reset64: vld=%b rdy=%b imm=%h, expected 0 1 0",
                     if64.out_valid, if64.in_ready, if64.out_imm);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
    endtask

    task automatic test_stream32();
        logic [31:0] t_inst [10];
        logic [31:0] t_imm  [10];
        logic [2:0]  t_fmt  [10];
        t_inst = '{32'hFAB00013, 32'hFE512E23, 32'hFE029AE3, 32'h00A38863, 32'h12345037,
                   32'h1234506F, 32'h00000033, 32'hFFFFFFFF, 32'h00509093, 32'h4030D093};
        t_imm  = '{32'hFFFFFFAB, 32'hFFFFFFFC, 32'hFFFFFFF4, 32'h00000010, 32'h12345000,
                   32'h00045922, 32'h00000000, 32'h00000000, 32'h00000005, 32'h00000003};
        t_fmt  = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd0, 3'd7, 3'd6, 3'd6};
        if32.out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (if32.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream32_idle: out_valid=%b expected 0", if32.out_valid);
        end
        for (int i = 0; i < 10; i++) begin
            if32.in_valid = 1'b1;
            if32.in_inst  = t_inst[i];
            if32.in_tag   = 32'(100 + i);
            @(posedge clk); #1;
            n_checks++;
            if (if32.out_valid !== 1'b1 || if32.out_imm !== t_imm[i] || if32.out_fmt !== t_fmt[i] ||
                if32.out_illegal !== (t_fmt[i] == 3'd7) || if32.out_tag !== 32'(100 + i) ||
                if32.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream32[%0d] inst=%h: vld=%b imm=%h fmt=%0d ill=%b tag=%0d rdy=%b, expected 1 %h %0d %b %0d 1",
                         i, t_inst[i], if32.out_valid, if32.out_imm, if32.out_fmt, if32.out_illegal,
                         if32.out_tag, if32.in_ready, t_imm[i], t_fmt[i], t_fmt[i] == 3'd7, 100 + i);
            end
        end
        if32.in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (if32.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream32_drain: out_valid=%b expected 0", if32.out_valid);
        end
    endtask

    task automatic test_xlen64();
        logic [31:0] t_inst [4];
        logic [63:0] t_imm  [4];
        logic [2:0]  t_fmt  [4];
        t_inst = '{32'h03F09093, 32'hFAB00013, 32'h80000037, 32'h4030D093};
        t_imm  = '{64'd63, 64'hFFFFFFFFFFFFFFAB, 64'hFFFFFFFF80000000, 64'd3};
        t_fmt  = '{3'd6, 3'd1, 3'd4, 3'd6};
        if64.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if64.in_valid = 1'b1;
            if64.in_inst  = t_inst[i];
            if64.in_tag   = 32'(200 + i);
            @(posedge clk); #1;
            n_checks++;
            if (if64.out_valid !== 1'b1 || if64.out_imm !== t_imm[i] || if64.out_fmt !== t_fmt[i] ||
                if64.out_tag !== 32'(200 + i)) begin
                n_fail++;
                $display("FAIL xlen64[%0d] inst=%h: vld=%b imm=%h fmt=%0d tag=%0d, expected 1 %h %0d %0d",
                         i, t_inst[i], if64.out_valid, if64.out_imm, if64.out_fmt, if64.out_tag,
                         t_imm[i], t_fmt[i], 200 + i);
            end
        end
        if64.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [31:0] held_imm;
        if32.out_ready = 1'b0;
        if32.in_valid  = 1'b1; if32.in_inst = 32'h00100093; if32.in_tag = 32'd1;
        @(posedge clk); #1;
        n_checks++;
        if (if32.out_valid !== 1'b1 || if32.out_tag !== 32'd1 || if32.in_ready !== 1'b1 ||
            if32.out_imm !== 32'd1) begin
            n_fail++;
            $display("FAIL bp_first: vld=%b tag=%0d rdy=%b imm=%h, expected 1 1 1 1",
                     if32.out_valid, if32.out_tag, if32.in_ready, if32.out_imm);
        end
        held_imm = if32.out_imm;
        if32.in_inst = 32'hFFF00093; if32.in_tag = 32'd2;
        @(posedge clk); #1;
        n_checks++;
        if (if32.in_ready !== 1'b0 || if32.out_tag !== 32'd1 || if32.out_imm !== 32'd1) begin
            n_fail++;
            $display("FAIL bp_second: rdy=%b tag=%0d imm=%h, expected 0 1 1",
                     if32.in_ready, if32.out_tag, if32.out_imm);
        end
        if32.in_inst = 32'h12345037; if32.in_tag = 32'd3;
        @(posedge clk); #1;
        n_checks++;
        if (if32.in_ready !== 1'b0 || if32.out_valid !== 1'b1 || if32.out_tag !== 32'd1 ||
            if32.out_imm !== held_imm || if32.out_fmt !== 3'd1) begin
            n_fail++;
            $display("FAIL bp_stable: rdy=%b vld=%b tag=%0d imm=%h fmt=%0d, expected 0 1 1 %h 1",
                     if32.in_ready, if32.out_valid, if32.out_tag, if32.out_imm, if32.out_fmt, held_imm);
        end
        if32.out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (if32.out_tag !== 32'd2 || if32.out_imm !== 32'hFFFFFFFF || if32.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_drain1: tag=%0d imm=%h rdy=%b, expected 2 ffffffff 1",
                     if32.out_tag, if32.out_imm, if32.in_ready);
        end
        @(posedge clk); #1;
        if32.in_valid = 1'b0;
        n_checks++;
        if (if32.out_valid !== 1'b1 || if32.out_tag !== 32'd3 || if32.out_imm !== 32'h12345000 ||
            if32.out_fmt !== 3'd4) begin
            n_fail++;
            $display("FAIL bp_drain2: vld=%b tag=%0d imm=%h fmt=%0d, expected 1 3 12345000 4",
                     if32.out_valid, if32.out_tag, if32.out_imm, if32.out_fmt);
        end
        @(posedge clk); #1;
        n_checks++;
        if (if32.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty: out_valid=%b expected 0", if32.out_valid);
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [12];
        logic [63:0] eq_imm [$];
        logic [2:0]  eq_fmt [$];
        logic [31:0] eq_tag [$];
        logic [63:0] e_imm;
        logic [2:0]  e_fmt;
        logic [31:0] r;
        logic [31:0] s_imm;
        logic [2:0]  s_fmt;
        logic        s_ill;
        logic [31:0] s_tag;
        int  sent;
        int  got;
        int  cyc;
        bit  acc;
        bit  stall;
        ops = '{7'h03, 7'h0F, 7'h67, 7'h73, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B};
        sent = 0; got = 0; cyc = 0; acc = 1'b1; stall = 1'b0;
        s_imm = '0; s_fmt = '0; s_ill = 1'b0; s_tag = '0;
        while (got < 1000 && cyc < 20000) begin
            @(posedge clk); #1;
            if (!if32.in_valid || acc) begin
                if (sent < 1000 && $urandom_range(0, 9) < 7) begin
                    r = $urandom();
                    if ($urandom_range(0, 12) != 0) r[6:0] = ops[$urandom_range(0, 11)];
                    if32.in_valid = 1'b1;
                    if32.in_inst  = r;
                    if32.in_tag   = $urandom();
                end else begin
                    if32.in_valid = 1'b0;
                end
            end
            if32.out_ready = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            n_checks++;
            if (if32.out_valid !== (eq_imm.size() > 0) || if32.in_ready !== (eq_imm.size() < 2)) begin
                n_fail++;
                $display("FAIL rand_occupancy cyc %0d: vld=%b rdy=%b, expected %b %b",
                         cyc, if32.out_valid, if32.in_ready, eq_imm.size() > 0, eq_imm.size() < 2);
            end
            if (stall) begin
                n_checks++;
                if (if32.out_imm !== s_imm || if32.out_fmt !== s_fmt ||
                    if32.out_illegal !== s_ill || if32.out_tag !== s_tag) begin
                    n_fail++;
                    $display("FAIL rand_stable cyc %0d: imm=%h fmt=%0d ill=%b tag=%h, expected %h %0d %b %h",
                             cyc, if32.out_imm, if32.out_fmt, if32.out_illegal, if32.out_tag,
                             s_imm, s_fmt, s_ill, s_tag);
                end
            end
            if (if32.out_valid && if32.out_ready) begin
                n_checks++;
                if (eq_imm.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_spurious cyc %0d: output tag %h with nothing outstanding",
                             cyc, if32.out_tag);
                end else begin
                    e_imm = eq_imm.pop_front();
                    e_fmt = eq_fmt.pop_front();
                    if (if32.out_imm !== e_imm[31:0] || if32.out_fmt !== e_fmt ||
                        if32.out_illegal !== (e_fmt == 3'd7) || if32.out_tag !== eq_tag[0]) begin
                        n_fail++;
                        $display("FAIL rand_data #%0d: imm=%h fmt=%0d ill=%b tag=%h, expected %h %0d %b %h",
                                 got, if32.out_imm, if32.out_fmt, if32.out_illegal, if32.out_tag,
                                 e_imm[31:0], e_fmt, e_fmt == 3'd7, eq_tag[0]);
                    end
                    void'(eq_tag.pop_front());
                end
                got++;
            end
            acc = if32.in_valid && if32.in_ready;
            if (acc) begin
                ref_decode(if32.in_inst, 1'b0, e_imm, e_fmt);
                eq_imm.push_back(e_imm);
                eq_fmt.push_back(e_fmt);
                eq_tag.push_back(if32.in_tag);
                sent++;
            end
            stall = if32.out_valid && !if32.out_ready;
            s_imm = if32.out_imm; s_fmt = if32.out_fmt; s_ill = if32.out_illegal; s_tag = if32.out_tag;
            cyc++;
        end
        n_checks++;
        if (got != 1000 || sent != 1000) begin
            n_fail++;
            $display("FAIL rand_complete: sent=%0d received=%0d after %0d cycles, expected 1000 1000",
                     sent, got, cyc);
        end
        @(posedge clk); #1;
        if32.in_valid  = 1'b0;
        if32.out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        if32.out_ready = 1'b0;
        if32.in_valid  = 1'b1; if32.in_inst = 32'h00500013; if32.in_tag = 32'hA1;
        @(posedge clk); #1;
        if32.in_tag = 32'hA2;
        @(posedge clk); #1;
        if32.in_valid = 1'b0;
        n_checks++;
        if (if32.out_valid !== 1'b1 || if32.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_full: vld=%b rdy=%b, expected 1 0", if32.out_valid, if32.in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (if32.out_valid !== 1'b0 || if32.in_ready !== 1'b1 || if32.out_tag !== 32'h0 ||
            if32.out_imm !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_async: vld=%b rdy=%b tag=%h imm=%h, expected 0 1 0 0",
                     if32.out_valid, if32.in_ready, if32.out_tag, if32.out_imm);
        end
        #2;
        rst_n = 1'b1;
        if32.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (if32.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_stale[%0d]: out_valid=%b tag=%h, expected 0", i,
                         if32.out_valid, if32.out_tag);
            end
        end
        if32.in_valid = 1'b1; if32.in_inst = 32'h0000006F; if32.in_tag = 32'hB1;
        @(posedge clk); #1;
        if32.in_valid = 1'b0;
        n_checks++;
        if (if32.out_valid !== 1'b1 || if32.out_tag !== 32'hB1 || if32.out_fmt !== 3'd5 ||
            if32.out_imm !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_recover: vld=%b tag=%h fmt=%0d imm=%h, expected 1 b1 5 0",
                     if32.out_valid, if32.out_tag, if32.out_fmt, if32.out_imm);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_stream32();
        test_xlen64();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
